// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
//   Time-multiplexes one W-bit adder between N requesters. A round-robin
//   arbiter grants at most one requester per cycle; the granted operand pair
//   is summed and registered into a single-entry response buffer tagged with
//   the requester index. The buffer refills in the same cycle it is drained,
//   so a continuously ready consumer sees one result per cycle.
//
// Parameters
//   N   number of requesters (2..16)
//   W   operand width
//   IDW response tag width, equal to clog2(N)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [N]     per-requester request valid (held until granted)
//   req_a      [N*W]   operand A, requester i at [i*W +: W]
//   req_b      [N*W]   operand B, same packing
//   req_grant  [N]     one-hot combinational grant; operands captured on the
//                      clock edge where the bit is high
//   rsp_valid          response buffer holds a result
//   rsp_ready          consumer accepts the response
//   rsp_id     [IDW]   requester index of the buffered result
//   rsp_sum    [W+1]   a + b with carry in the MSB
//
// Optional build macro SHARED_ADDER_STATS_EN adds:
//   stat_grants [16]   saturating count of cycles with a grant
//   stat_stalls [16]   saturating count of cycles with requests pending but
//                      the buffer full and not being drained
module shared_adder_arbiter #(
  parameter int N   = 4,
  parameter int W   = 13,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_grant,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W:0]     rsp_sum
`ifdef SHARED_ADDER_STATS_EN
  ,
  output logic [15:0]    stat_grants,
  output logic [15:0]    stat_stalls
`endif
);

  // Response buffer occupancy
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic           state_reg;
  logic [IDW-1:0] last_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [W:0]     rsp_sum_reg;

  logic           can_accept;
  logic [N-1:0]   grant_next;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [W:0]     sum_next;

  // Unpack the flat operand buses into per-requester lanes
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // A full buffer can still take a new result if it is being drained now
  assign can_accept = (state_reg == ST_EMPTY) || rsp_ready;

  // Round-robin search starting just after the last granted requester.
  // The candidate index is formed in IDW+1 bits so last+k (at most 2N-1)
  // never overflows before the wrap correction.
  always_comb begin
    logic [IDW:0] cand;
    grant_next = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    cand       = '0;
    if (can_accept) begin
      for (int k = 1; k <= N; k++) begin
        cand = {1'b0, last_reg} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(N)) begin
          cand = cand - (IDW+1)'(N);
        end
        if (!grant_any && req_valid[cand[IDW-1:0]]) begin
          grant_any                  = 1'b1;
          grant_idx                  = cand[IDW-1:0];
          grant_next[cand[IDW-1:0]] = 1'b1;
        end
      end
    end
  end

  // The single shared adder: operands are muxed in front of it
  assign sel_a    = a_arr[grant_idx];
  assign sel_b    = b_arr[grant_idx];
  assign sum_next = {1'b0, sel_a} + {1'b0, sel_b};

  // No grant may be seen while reset is asserted
  assign req_grant = rst_n ? grant_next : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_EMPTY;
      last_reg    <= IDW'(N-1);
      rsp_id_reg  <= '0;
      rsp_sum_reg <= '0;
    end else if (grant_any) begin
      // Covers both refill of an empty buffer and replace-on-accept
      state_reg   <= ST_FULL;
      last_reg    <= grant_idx;
      rsp_id_reg  <= grant_idx;
      rsp_sum_reg <= sum_next;
    end else if (rsp_ready) begin
      state_reg   <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state_reg == ST_FULL);
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;

`ifdef SHARED_ADDER_STATS_EN
  logic [15:0] stat_grants_reg;
  logic [15:0] stat_stalls_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_reg <= '0;
      stat_stalls_reg <= '0;
    end else begin
      if (grant_any && (stat_grants_reg != 16'hFFFF)) begin
        stat_grants_reg <= stat_grants_reg + 16'd1;
      end
      if ((|req_valid) && !can_accept && (stat_stalls_reg != 16'hFFFF)) begin
        stat_stalls_reg <= stat_stalls_reg + 16'd1;
      end
    end
  end

  assign stat_grants = stat_grants_reg;
  assign stat_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Self-checking bench for shared_adder_arbiter (N=4, W=13).
// A reference model predicts each cycle's grant; every predicted grant
// pushes the expected {id, sum} into a scoreboard queue that is compared
// against rsp_id/rsp_sum while the DUT presents the result.
module tb_shared_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 13;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_grant;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W:0]     rsp_sum;
`ifdef SHARED_ADDER_STATS_EN
  logic [15:0]    stat_grants;
  logic [15:0]    stat_stalls;
`endif

  shared_adder_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_grant (req_grant),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef SHARED_ADDER_STATS_EN
    .rsp_sum   (rsp_sum),
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`else
    .rsp_sum   (rsp_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W:0] sum;
  } rsp_t;

  rsp_t         sb_q[$];
  logic [W-1:0] a_t [N];
  logic [W-1:0] b_t [N];
  int           m_last;
  logic         m_valid;
  logic         one_shot;
  logic [N-1:0] seen_grant;
  int           n_cmp;
  int           n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_t[i] = a;
    b_t[i] = b;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_valid = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive inputs.
  task automatic cycle();
    logic [N-1:0] eg;
    logic         can;
    int           g;
    int           idx;
    rsp_t         e;
    @(negedge clk);
    can = !m_valid || rsp_ready;
    eg  = '0;
    g   = -1;
    if (can) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    seen_grant = req_grant;
    check_val("grant", {28'd0, req_grant}, {28'd0, eg});
    check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    if (m_valid && sb_q.size() > 0) begin
      e = sb_q[0];
      check_val("rsp_id", {30'd0, rsp_id}, e.id);
      check_val("rsp_sum", {18'd0, rsp_sum}, {18'd0, e.sum});
      if (rsp_ready) void'(sb_q.pop_front());
    end
    if (g >= 0) begin
      e.id  = g;
      e.sum = {1'b0, a_t[g]} + {1'b0, b_t[g]};
      sb_q.push_back(e);
      m_last  = g;
      m_valid = 1'b1;
      $display("txn grant=%0d a=%0d b=%0d exp_sum=%0d", g, a_t[g], b_t[g], e.sum);
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (one_shot && g >= 0) req_valid[g] = 1'b0;
  endtask

  // Hard time bound in case the design stalls the clocked flow
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    one_shot  = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, '0, '0);
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_id", {30'd0, rsp_id}, 32'd0);
    check_val("rst_sum", {18'd0, rsp_sum}, 32'd0);
    req_valid = 4'b1111;
    #1;
    check_val("rst_grant", {28'd0, req_grant}, 32'd0);
    req_valid = '0;
`ifdef SHARED_ADDER_STATS_EN
    check_val("rst_stat_g", {16'd0, stat_grants}, 32'd0);
    check_val("rst_stat_s", {16'd0, stat_stalls}, 32'd0);
`endif
    rst_n = 1'b1;

    // Basic single request: 100 + 23
    set_op(0, 13'd100, 13'd23);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    cycle();
    check_val("t1_grant", {28'd0, seen_grant}, 32'h1);
    check_val("t1_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("t1_id", {30'd0, rsp_id}, 32'd0);
    check_val("t1_sum", {18'd0, rsp_sum}, 32'd123);

    // Carry out of the top operand bit
    set_op(1, 13'h1FFF, 13'd1);
    req_valid = 4'b0010;
    cycle();
    check_val("carry_id", {30'd0, rsp_id}, 32'd1);
    check_val("carry_sum", {18'd0, rsp_sum}, 32'h2000);
    cycle();

    // All requesters continuously valid: rotation resumes after requester 1
    one_shot = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, W'(1000 * (i + 1)), W'(7 * i + 3));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_val("rr_order", {28'd0, seen_grant}, 32'(1 << ((k + 2) % N)));
    end

    // Stall with requester 2 waiting (last grant went to requester 1)
    one_shot  = 1'b1;
    req_valid = 4'b0100;
    set_op(2, 13'd4000, 13'd96);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val("stall_grant", {28'd0, seen_grant}, 32'd0);
      check_val("stall_hold_id", {30'd0, rsp_id}, 32'd1);
    end
    rsp_ready = 1'b1;
    cycle();
    check_val("unstall_grant", {28'd0, seen_grant}, 32'h4);
    check_val("unstall_id", {30'd0, rsp_id}, 32'd2);
    check_val("unstall_sum", {18'd0, rsp_sum}, 32'd4096);
    cycle();

    // Randomized traffic respecting the hold-until-granted rule
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, W'($urandom), W'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();

    // Asynchronous reset while a result is buffered
    set_op(3, 13'd5, 13'd6);
    req_valid = 4'b1000;
    cycle();
    check_val("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 4'b1010;
    #1;
    check_val("arst_grant", {28'd0, req_grant}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_op(1, 13'd11, 13'd22);
    set_op(3, 13'd33, 13'd44);
    cycle();
    check_val("post_rst_grant", {28'd0, seen_grant}, 32'h2);
    cycle();
    check_val("post_rst_id", {30'd0, rsp_id}, 32'd3);
    req_valid = '0;
    cycle();

`ifdef SHARED_ADDER_STATS_EN
    // Fresh counters: 5 grants then 3 stalled cycles
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_op(0, 13'd1, 13'd2);
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0001;
      cycle();
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) cycle();
    check_val("stat_grants", {16'd0, stat_grants}, 32'd5);
    check_val("stat_stalls", {16'd0, stat_stalls}, 32'd3);
    rsp_ready = 1'b1;
    cycle();
    cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shared_adder_arbiter.md
Name: shared_adder_arbiter

Overview:
- Shares one W-bit adder between N independent requesters.
- Each requester presents an operand pair with a valid/grant handshake. A round-robin arbiter picks one requester per cycle, and the sum is registered into a single-entry response buffer tagged with the requester index.
- Sits between the generated state-machine datapaths and the shared Bin-style adder resource, so several sequencers can time-multiplex one adder.

Parameters:
- N, 4, number of requesters (2..16).
- W, 13, operand width in bits.
- IDW, 2, response tag width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: asynchronous assert, active-low.
- req_valid  input  N  per-requester request valid.
- req_a  input  N*W  operand A per requester; requester i occupies bits [i*W +: W].
- req_b  input  N*W  operand B per requester; same packing as req_a.
- req_grant  output  N  one-hot grant; combinational; operands are captured at the clock edge where it is high.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that produced rsp_sum.
- rsp_sum  output  W+1  req_a + req_b, zero-extended, carry kept in the MSB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_sum=0.
  - Round-robin pointer last=N-1, so requester 0 has first priority.
  - req_grant=0 while rst_n is low.
- can_accept = !rsp_valid || rsp_ready. Because of this term the buffer gives full throughput: one grant per cycle under a continuous rsp_ready.
- Arbitration (combinational):
  - If can_accept and any req_valid is set, grant the first set bit searching from (last+1) mod N upward, wrapping around.
  - Exactly one req_grant bit is high, otherwise all are zero.
  - Wrap-around: after granting N-1, the search starts at 0.
- Capture at a clock edge with a grant to requester g:
  - rsp_sum <= {1'b0,a_g} + {1'b0,b_g}.
  - rsp_id <= g.
  - rsp_valid <= 1.
  - last <= g.
- No grant and rsp_ready=1: rsp_valid <= 0; rsp_sum and rsp_id hold their last values.
- No grant and rsp_ready=0: all state holds.
- Latency: the result is visible on rsp_* in the cycle after its grant.
- Requester rules:
  - Once req_valid is asserted it stays high, with operands stable, until granted.
  - Dropping req_valid without a grant is a protocol error. The arbiter does not check for it.
- Response-buffer FSM:
  - EMPTY (rsp_valid=0): a grant moves it to FULL.
  - FULL with rsp_ready=1: a new grant stays in FULL (back-to-back); no grant moves it to EMPTY.
  - FULL with rsp_ready=0: stalls; all req_grant bits are 0 and the contents are held.
- Simultaneous response accept and new grant in the same cycle: the new result replaces the old one with no bubble.
- Fairness: a requester that holds req_valid waits at most N-1 grants, counted only over cycles where can_accept=1.
- Reset mid-operation: any pending result is discarded, no grant is issued, and the pointer returns to N-1.

Optional Feature:
- Macro SHARED_ADDER_STATS_EN.
- When defined, adds output stat_grants[15:0] and output stat_stalls[15:0]:
  - stat_grants counts cycles with any grant.
  - stat_stalls counts cycles with req_valid!=0 and can_accept=0.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0001, a0=13'd100, b0=13'd23, rsp_ready=1:
  - req_grant=4'b0001 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_sum=14'd123.
- Carry: a=13'h1FFF, b=13'd1 -> rsp_sum=14'h2000.
- All four requesters valid continuously, rsp_ready=1:
  - Grants go 0,1,2,3,0,… one per cycle.
  - rsp_id follows the same order one cycle later.
- rsp_ready=0 with rsp_valid=1 and requester 2 waiting:
  - req_grant=0 and the buffer is held for 3 cycles.
  - Raise rsp_ready: the old result is accepted, requester 2 is granted in that cycle, and its sum appears in the next cycle.
- Assert rst_n=0 asynchronously mid-cycle while rsp_valid=1:
  - rsp_valid drops immediately.
  - After release with req_valid=4'b1010, requester 1 is granted first.
- With SHARED_ADDER_STATS_EN: 5 grants and then 3 stalled cycles -> stat_grants=5, stat_stalls=3.
